board_responder: RTL
====================

BOARD_RESPONDER -- requirements
Module: board_responder

Interface
REQ-001 Parameter BOARD_W, default 16: number of board cells, one per switch.
REQ-002 clk  in  1: single system clock; all state updates on its rising edge.
REQ-003 clr  in  1: reset, asynchronous and active-high; one clock, async active-high reset, as already decided.
REQ-004 sw  in  BOARD_W: switch bank; a set bit marks a ship cell (load phase) or a targeted cell (attack phase).
REQ-005 ld_ships  in  1: load-ships strobe from the game controller (LDR1 role).
REQ-006 ld_attack  in  1: load-attack strobe from the game controller (LDR2 role).
REQ-007 busy  out  1: high while a check is in progress.
REQ-008 ok_valid  out  1: one-cycle pulse marking the end of a check.
REQ-009 ok  out  1: check verdict; meaningful only while ok_valid is high.
REQ-010 hit  out  1: one-cycle pulse alongside ok_valid when the accepted shot struck a ship.
REQ-011 alive  out  1: high while at least one ship cell is still unhit (Liv role).
REQ-012 shots  out  5: count of accepted shots, saturating at 31.

Function
REQ-013 Registers: ship_reg[BOARD_W], shot_reg[BOARD_W], cand_reg[BOARD_W], idx[4], new_cnt[2], removed[1].
REQ-014 FSM states: IDLE, SCAN, DONE.
REQ-015 IDLE, ld_ships=1: ship_reg<=sw, shot_reg<=0, shots<=0; stay in IDLE.
REQ-016 IDLE, ld_attack=1, ld_ships=0: cand_reg<=sw, idx<=0, new_cnt<=0, removed<=0; go to SCAN.
REQ-017 IDLE, both strobes high in the same cycle: ld_ships wins and ld_attack is dropped.
REQ-018 SCAN, each cycle:
- If cand[idx]&~shot[idx], new_cnt increments, saturating at 2.
- If ~cand[idx]&shot[idx], removed<=1.
- idx increments; after idx=BOARD_W-1 the FSM goes to DONE.
REQ-019 DONE lasts one cycle: ok_valid=1 and ok=(new_cnt==1 && !removed); the FSM then returns to IDLE.
REQ-020 DONE with ok=1:
- shot_reg<=cand_reg.
- shots increments, saturating.
- hit=|(ship_reg & cand_reg & ~shot_reg).
REQ-021 DONE with ok=0: shot_reg and shots are unchanged and hit=0.
REQ-022 Latency: ld_attack sampled at edge N gives ok_valid high in cycle N+BOARD_W+1 (17 for the default).
REQ-023 busy=1 in SCAN and DONE, 0 in IDLE.
REQ-024 Both strobes are ignored while busy; no queuing.
REQ-025 sw changes during SCAN have no effect, because only cand_reg is scanned.
REQ-026 alive=|(ship_reg & ~shot_reg), combinational from registers.
REQ-027 alive=0 when ship_reg is all-zero.
REQ-028 ok and hit are 0 whenever ok_valid=0.

Reset
REQ-029 clr high forces, immediately, state=IDLE and all registers to 0, including mid-SCAN.
REQ-030 Output values under clr: busy=0, ok_valid=0, ok=0, hit=0, alive=0, shots=0.
REQ-031 A check aborted by clr produces no ok_valid pulse.
REQ-032 After clr falls, the first strobe is accepted on the next clock edge.

Structure
REQ-033 Shared package contents: the state enum {IDLE, SCAN, DONE}, the BOARD_W default and the shots counter width.
REQ-034 The block is a single module with no sub-module; the scan datapath is inline.
REQ-035 One instance per player; the controller's OK and Liv inputs connect to ok and alive.

Verification
REQ-036 ld_ships with sw=16'h0003, then ld_attack with sw=16'h0001 -> busy for 17 cycles, ok_valid at N+17 with ok=1 and hit=1, shots=1, alive=1.
REQ-037 Continuing, ld_attack with sw=16'h0003 -> ok=1, hit=1, alive=0, shots=2.
REQ-038 With shot_reg=16'h0001, ld_attack with sw=16'h0006 (two new cells) -> ok=0, hit=0, shot_reg unchanged.
REQ-039 With shot_reg=16'h0001, ld_attack with sw=16'h0002 (cell 0 cleared) -> ok=0.
REQ-040 ld_attack, then clr pulsed at cycle N+8 -> no ok_valid pulse, all outputs 0, next ld_ships accepted.
REQ-041 ld_ships and ld_attack in the same cycle -> ships loaded and busy stays 0; ld_attack during SCAN -> ignored, exactly one ok_valid pulse.

Source files
------------

// File: rtl/board_responder_pkg.sv
// Shared types and sizing for the battleship board responder.
package board_responder_pkg;
  localparam int BOARD_W_DEF = 16;
  localparam int SHOTS_W     = 5;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
endpackage

// File: rtl/board_responder_if.sv
// Controller-to-responder bundle: switch bank, load strobes and the check/status results.
interface board_responder_if #(parameter int BOARD_W = board_responder_pkg::BOARD_W_DEF);
  logic [BOARD_W-1:0]                      sw;
  logic                                    ld_ships;
  logic                                    ld_attack;
  logic                                    busy;
  logic                                    ok_valid;
  logic                                    ok;
  logic                                    hit;
  logic                                    alive;
  logic [board_responder_pkg::SHOTS_W-1:0] shots;

  modport master (output sw, ld_ships, ld_attack,
                  input  busy, ok_valid, ok, hit, alive, shots);
  modport slave  (input  sw, ld_ships, ld_attack,
                  output busy, ok_valid, ok, hit, alive, shots);
endinterface

// File: rtl/board_responder.sv
// Per-player board: holds ships and accepted shots, and validates each new attack pattern
// by scanning it one cell per cycle (exactly one new cell, no previously shot cell cleared).
module board_responder
  import board_responder_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_DEF
) (
  input  logic            clk,
  input  logic            clr,
  board_responder_if.slave bus
);
  localparam int IDX_W = (BOARD_W > 1) ? $clog2(BOARD_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BOARD_W - 1);

  state_t               state;
  logic [BOARD_W-1:0]   ship_reg, shot_reg, cand_reg;
  logic [IDX_W-1:0]     idx;
  logic [1:0]           new_cnt;
  logic                 removed;
  logic                 busy_r, ok_valid_r, ok_r, hit_r;
  logic [SHOTS_W-1:0]   shots_r;

  logic                 new_cell;
  logic [1:0]           cnt_nxt;
  logic                 rem_nxt;
  logic                 ok_nxt;
  logic                 strike;

  // Scan step for the current cell, folded in so the verdict is ready on the last SCAN edge.
  always_comb begin
    new_cell = cand_reg[idx] & ~shot_reg[idx];
    cnt_nxt  = new_cnt;
    if (new_cell && (new_cnt != 2'd2))
      cnt_nxt = new_cnt + 2'd1;
    rem_nxt  = removed | (~cand_reg[idx] & shot_reg[idx]);
    ok_nxt   = (cnt_nxt == 2'd1) && !rem_nxt;
    strike   = |(ship_reg & cand_reg & ~shot_reg);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      ship_reg   <= '0;
      shot_reg   <= '0;
      cand_reg   <= '0;
      idx        <= '0;
      new_cnt    <= '0;
      removed    <= 1'b0;
      busy_r     <= 1'b0;
      ok_valid_r <= 1'b0;
      ok_r       <= 1'b0;
      hit_r      <= 1'b0;
      shots_r    <= '0;
    end else begin
      ok_valid_r <= 1'b0;
      ok_r       <= 1'b0;
      hit_r      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ld_ships) begin
            ship_reg <= bus.sw;
            shot_reg <= '0;
            shots_r  <= '0;
          end else if (bus.ld_attack) begin
            cand_reg <= bus.sw;
            idx      <= '0;
            new_cnt  <= '0;
            removed  <= 1'b0;
            busy_r   <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          new_cnt <= cnt_nxt;
          removed <= rem_nxt;
          idx     <= idx + IDX_W'(1);
          if (idx == IDX_LAST) begin
            ok_valid_r <= 1'b1;
            ok_r       <= ok_nxt;
            hit_r      <= ok_nxt & strike;
            state      <= DONE;
          end
        end
        DONE: begin
          // Commit happens while the verdict is on the outputs, so shots/alive move one cycle later.
          if (ok_r) begin
            shot_reg <= cand_reg;
            if (shots_r != '1)
              shots_r <= shots_r + SHOTS_W'(1);
          end
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.ok_valid = ok_valid_r;
  assign bus.ok       = ok_r;
  assign bus.hit      = hit_r;
  assign bus.alive    = |(ship_reg & ~shot_reg);
  assign bus.shots    = shots_r;
endmodule
